// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types and the round-robin selection rule used by dpram_port_arbiter.
package dpram_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [MAX_REQ-1:0] req_vec_t;

  typedef enum logic {
    ARB,
    CLEAR
  } arb_state_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } rr_result_t;

  // First requesting index strictly after `last`, wrapping at nreq.
  function automatic rr_result_t rr_next(input idx_t last, input req_vec_t req,
                                         input int unsigned nreq);
    rr_result_t  res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      pos = 32'(last) + k;
      if (pos >= nreq) pos = pos - nreq;
      if (k <= nreq && !res.valid && req[pos[IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = idx_t'(pos);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus encoded index.
module rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  idx_t            last,
  output logic [NREQ-1:0] grant,
  output idx_t            idx,
  output logic            valid
);

  req_vec_t   req_ext;
  rr_result_t pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_next(last, req_ext, NREQ);
    valid              = pick.valid;
    idx                = pick.idx;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = pick.valid && (pick.idx == idx_t'(i));
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin sharing of one dpram port among NREQ requesters, with a
// sequencer that fills the whole RAM with FILL_VALUE on a clear pulse.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           NREQ       = 3,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  output logic                       clear_busy,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            ack,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0]      ram_address,
  output logic [DATA_WIDTH-1:0]      ram_data,
  output logic                       ram_enable,
  output logic                       ram_wren,
  output logic                       ram_cs,
  input  logic [DATA_WIDTH-1:0]      ram_q
);

  arb_state_t            state;
  arb_state_t            state_next;
  idx_t                  last;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [NREQ-1:0]       grant;
  idx_t                  grant_idx;
  logic                  grant_valid;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  // One-hot field mux driven by the picker's grant vector.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = we[i];
      end
    end
  end

  // clear wins over any request presented in the same cycle.
  assign accept = (state == ARB) && !clear && grant_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (clear) state_next = CLEAR;
      CLEAR:   if (!clear && clr_cnt == '1) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last    <= idx_t'(NREQ - 1);
      clr_cnt <= '0;
      rvalid  <= '0;
    end else begin
      rvalid <= (accept && !sel_we) ? grant : '0;
      if (accept) last <= grant_idx;
      if (clear || state == ARB) clr_cnt <= '0;
      else                       clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    ack         = '0;
    clear_busy  = 1'b0;
    ram_enable  = 1'b0;
    ram_wren    = 1'b0;
    ram_address = sel_addr;
    ram_data    = sel_wdata;
    case (state)
      CLEAR: begin
        clear_busy  = 1'b1;
        ram_enable  = 1'b1;
        ram_wren    = 1'b1;
        ram_address = clr_cnt;
        ram_data    = FILL_VALUE;
      end
      default: begin
        if (accept) begin
          ack        = grant;
          ram_enable = 1'b1;
          ram_wren   = sel_we;
        end
      end
    endcase
  end

  assign ram_cs = 1'b1;
  assign rdata  = ram_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: cycle-level reference model plus directed scenarios.
module tb_dpram_port_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned NR    = 3;
  localparam int unsigned DEPTH = 256;
  localparam logic [DW-1:0] FILL = 8'h00;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             clear_busy;
  logic [NR-1:0]    req;
  logic [NR-1:0]    we;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    ack;
  logic [NR-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic [AW-1:0]    ram_address;
  logic [DW-1:0]    ram_data;
  logic             ram_enable;
  logic             ram_wren;
  logic             ram_cs;
  logic [DW-1:0]    ram_q;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dpram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NREQ       (NR),
    .FILL_VALUE (FILL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .clear_busy  (clear_busy),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_enable  (ram_enable),
    .ram_wren    (ram_wren),
    .ram_cs      (ram_cs),
    .ram_q       (ram_q)
  );

  // Synchronous-read RAM port standing in for the dpram.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      ram_q <= ram_mem[ram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining-fill countdown, rotating priority, expected memory.
  logic          run_model = 1'b0;
  int            m_last = NR - 1;
  int            m_busy_left = 0;
  int            m_fill_pos = 0;
  int            m_pend_req = 0;
  logic          m_pend = 1'b0;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] ref_mem [DEPTH];

  always @(negedge clock) begin : model
    int            g;
    int            idx;
    logic          busy_e, en_e, wr_e, w_g;
    logic [NR-1:0] ack_e, rv_e;
    logic [AW-1:0] a_g, a_e;
    logic [DW-1:0] d_g, d_e;
    if (run_model) begin
      busy_e = (m_busy_left > 0);
      g = -1;
      if (!busy_e && !clear) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (g < 0 && req[idx]) g = idx;
        end
      end
      a_g = '0;
      d_g = '0;
      w_g = 1'b0;
      if (g >= 0) begin
        a_g = addr[g*AW +: AW];
        d_g = wdata[g*DW +: DW];
        w_g = we[g];
      end
      ack_e = (g >= 0) ? NR'(1 << g) : '0;
      rv_e  = m_pend ? NR'(1 << m_pend_req) : '0;
      en_e  = busy_e || (g >= 0);
      wr_e  = busy_e || (g >= 0 && w_g);
      a_e   = busy_e ? AW'(m_fill_pos) : a_g;
      d_e   = busy_e ? FILL : d_g;

      check("ack", ack, ack_e);
      check("rvalid", rvalid, rv_e);
      check("clear_busy", clear_busy, busy_e);
      check("ram_enable", ram_enable, en_e);
      check("ram_cs", ram_cs, 1);
      if (en_e) begin
        check("ram_wren", ram_wren, wr_e);
        check("ram_address", ram_address, a_e);
      end
      if (wr_e) check("ram_data", ram_data, d_e);
      if (m_pend) check("rdata", rdata, m_pend_data);

      // The RAM port still writes on the edge that closes a reset cycle.
      if (busy_e) ref_mem[m_fill_pos] = FILL;
      else if (g >= 0 && w_g) ref_mem[a_g] = d_g;

      if (reset) begin
        m_last      = NR - 1;
        m_busy_left = 0;
        m_fill_pos  = 0;
        m_pend      = 1'b0;
      end else begin
        m_pend      = (g >= 0) && !w_g;
        m_pend_req  = g;
        m_pend_data = ref_mem[a_g];
        if (g >= 0) m_last = g;
        if (busy_e) begin
          m_busy_left--;
          m_fill_pos++;
        end
        if (clear) begin
          m_busy_left = DEPTH;
          m_fill_pos  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req   = '0;
    we    = '0;
    clear = 1'b0;
  endtask

  task automatic drive(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]           = 1'b1;
    we[i]            = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  logic [NR-1:0] exp_fair [9];
  logic [NR-1:0] ack_seq  [9];
  logic [NR-1:0] rv_seq   [10];
  int            n;
  logic          got;

  initial begin
    exp_fair = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset = 1'b1;
    clear = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    run_model = 1'b1;
    @(negedge clock);
    check("reset ack", ack, 0);
    check("reset rvalid", rvalid, 0);
    check("reset clear_busy", clear_busy, 0);
    check("reset ram_enable", ram_enable, 0);
    check("reset ram_wren", ram_wren, 0);
    tick();
    reset = 1'b0;

    // Write 0xA5 to 0x10 via req0, read back via req2.
    drive(0, 1'b1, 8'h10, 8'hA5);
    @(negedge clock);
    check("single write ack", ack, 3'b001);
    tick();
    idle();
    drive(2, 1'b0, 8'h10, 8'h00);
    @(negedge clock);
    check("single read ack", ack, 3'b100);
    tick();
    idle();
    @(negedge clock);
    check("single read rvalid", rvalid, 3'b100);
    check("single read rdata", rdata, 8'hA5);
    tick();

    // Fairness under full read load.
    req = '1;
    we  = '0;
    for (int i = 0; i < NR; i++) addr[i*AW +: AW] = 8'h10;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      ack_seq[k] = ack;
      rv_seq[k]  = rvalid;
      tick();
    end
    idle();
    @(negedge clock);
    rv_seq[9] = rvalid;
    tick();
    check("fair rvalid before", rv_seq[0], 0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("fair ack %0d", k), ack_seq[k], exp_fair[k]);
      check($sformatf("fair rvalid %0d", k + 1), rv_seq[k+1], exp_fair[k]);
    end

    // Full clear; 0xFF is preloaded so the fill is visible.
    drive(1, 1'b1, 8'hFF, 8'h5A);
    tick();
    idle();
    clear = 1'b1;
    @(negedge clock);
    check("clear pulse cycle busy", clear_busy, 0);
    tick();
    clear = 1'b0;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (!clear_busy) break;
      n++;
      tick();
    end
    check("clear length", n, 256);
    tick();
    drive(0, 1'b0, 8'hFF, 8'h00);
    @(negedge clock);
    check("post-clear read ack", ack, 3'b001);
    tick();
    idle();
    @(negedge clock);
    check("post-clear rvalid", rvalid, 3'b001);
    check("post-clear rdata", rdata, 8'h00);
    tick();

    // clear in the same cycle as req[1].
    drive(1, 1'b0, 8'h20, 8'h00);
    clear = 1'b1;
    @(negedge clock);
    check("clear vs req ack", ack, 0);
    tick();
    clear = 1'b0;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      n++;
      if (ack != 0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("clear vs req got ack", got, 1);
    check("clear vs req ack cycle", n, 257);
    check("clear vs req ack value", ack, 3'b010);
    check("clear vs req busy at ack", clear_busy, 0);
    tick();
    idle();
    @(negedge clock);
    check("clear vs req rvalid", rvalid, 3'b010);
    tick();

    // Re-clear at fill cycle 100.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    for (int i = 0; i < 800; i++) begin
      clear = (n == 100);
      @(negedge clock);
      if (!clear_busy) break;
      n++;
      tick();
    end
    clear = 1'b0;
    check("re-clear length", n, 357);
    tick();

    // Reset at fill cycle 50 leaves a partial fill.
    drive(0, 1'b1, 8'h20, 8'h11);
    tick();
    idle();
    drive(0, 1'b1, 8'h80, 8'h77);
    tick();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (50) tick();
    reset = 1'b1;
    @(negedge clock);
    check("mid-clear busy at reset", clear_busy, 1);
    tick();
    reset = 1'b0;
    drive(0, 1'b0, 8'h80, 8'h00);
    @(negedge clock);
    check("after reset busy", clear_busy, 0);
    check("after reset ack", ack, 3'b001);
    tick();
    drive(0, 1'b0, 8'h20, 8'h00);
    @(negedge clock);
    check("unfilled word rvalid", rvalid, 3'b001);
    check("unfilled word rdata", rdata, 8'h77);
    tick();
    idle();
    @(negedge clock);
    check("filled word rdata", rdata, 8'h00);
    tick();

    // Reset in the ack cycle drops the pending rvalid.
    drive(2, 1'b0, 8'h80, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    check("reset-cycle ack", ack, 3'b100);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clock);
    check("dropped rvalid", rvalid, 0);
    tick();

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Shares one port of a true dual-port block RAM among `NREQ` requesters with round-robin arbitration and a one-request-per-cycle req/ack handshake. It also contains a clear sequencer that fills the whole RAM with a constant on command. It sits between the core's memory clients (CPU bus, DMA, video fetch) and port A or B of a `dpram` instance, and drives that port's address, data, enable, write-enable and chip-select pins directly.

## Interface
- `ADDR_WIDTH`, 8: RAM address width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: RAM data width.
- `NREQ`, 3: number of requesters, valid range 2..8.
- `FILL_VALUE`, 0: word written by the clear sequencer.

Ports (all synchronous to `clock`; **one clock; reset is synchronous and active-high**):
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: one-cycle pulse that starts a full-RAM fill.
- `clear_busy` out 1: high while the fill is running.
- `req` in NREQ: per-requester access request.
- `we` in NREQ: per-requester write flag, qualified by `req`.
- `addr` in NREQ*ADDR_WIDTH: packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata` in NREQ*DATA_WIDTH: packed write data, same packing rule.
- `ack` out NREQ: one-hot, high in the cycle the request is accepted.
- `rvalid` out NREQ: one-hot, read data valid for that requester.
- `rdata` out DATA_WIDTH: shared read data; meaningful only while some `rvalid` bit is high.
- `ram_address` out ADDR_WIDTH: RAM port address.
- `ram_data` out DATA_WIDTH: RAM port write data.
- `ram_enable` out 1: RAM port clock enable.
- `ram_wren` out 1: RAM port write enable.
- `ram_cs` out 1: RAM port chip select.
- `ram_q` in DATA_WIDTH: RAM port read data, unregistered output.

## Operation
- States:
  - ARB: normal arbitration.
  - CLEAR: fill in progress.
- Reset:
  - State goes to ARB; the round-robin pointer `last` is set to NREQ-1, so index 0 has first priority.
  - The clear counter is set to 0.
  - `ack`, `rvalid` and `clear_busy` are 0.
  - `ram_enable` and `ram_wren` are 0.
  - `ram_cs` is 1 at all times.
- ARB:
  - The grant goes to the first requesting index after `last`, in increasing order with wrap-around.
  - The grant is combinational. `ack[g]`, `ram_enable` and the RAM pins are driven in the same cycle from requester g's fields, with `ram_wren` = `we[g]`.
  - `last` <= g at the end of that cycle.
  - If no requester is asserting `req`: `ack` = 0 and `ram_enable` = 0.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `ack` is seen.
  - Back-to-back requests are allowed: keep `req` high and present the next fields in the cycle after `ack`.
- Read return: for a read acked in cycle t, `rvalid[g]` is 1 in cycle t+1 and `rdata` = `ram_q` in that cycle. Writes produce no `rvalid`.
- `clear` in ARB:
  - Enter CLEAR next cycle. `clear` has priority over requests in the same cycle, so that cycle has no ack.
  - A read acked in the cycle before still returns its `rvalid` normally.
- CLEAR:
  - Each cycle: `ram_address` = counter, `ram_data` = FILL_VALUE, `ram_enable` = 1, `ram_wren` = 1, `clear_busy` = 1, `ack` = 0.
  - The counter increments by 1 each cycle.
  - After writing address 2^ADDR_WIDTH-1, the counter wraps to 0 and the state returns to ARB in the next cycle.
- `clear` during CLEAR: the counter restarts at 0. Total length becomes 2^ADDR_WIDTH cycles from the new pulse.
- `reset` mid-CLEAR: the fill aborts immediately and the RAM is left partially filled. `reset` mid-handshake drops any pending `rvalid`.

## Timing
- Grant latency: 0 cycles, `ack` in the same cycle as `req` when uncontested.
- Read latency: 1 cycle from `ack` to `rvalid`.
- Throughput: one access per cycle across all requesters. Under full load each of NREQ requesters gets 1 of every NREQ cycles.
- Clear duration: exactly 2^ADDR_WIDTH cycles of `clear_busy` = 1, starting the cycle after the `clear` pulse.
- `clear_busy` falls in the same cycle ARB resumes. Arbitration can grant in that cycle.

## Structure
- Shared package `dpram_arb_pkg`:
  - state enum `arb_state_t` with values {ARB, CLEAR}.
  - function `rr_next(last, req)` returning the grant index and a valid flag.
- One sub-module, `rr_pick`: a parameterised round-robin priority picker taking `req` and `last` and returning a one-hot grant plus an index. It is purely combinational.
- Top level holds:
  - the state register, `last` and the clear counter;
  - the read-return pipeline register (one-hot `rvalid`);
  - the field muxes onto the RAM pins.

## Test plan
- Single read: after reset, write 0xA5 to addr 0x10 via req0. Then read 0x10 via req2. Required: `ack[2]` is seen in the same cycle as the request, and `rvalid[2]` = 1 with `rdata` = 0xA5 in the next cycle.
- Fairness: hold `req` = 3'b111 with reads for 9 cycles. Required ack sequence is 0,1,2,0,1,2,0,1,2, with each `rvalid` one cycle after its ack.
- Clear: with FILL_VALUE = 0x00, pulse `clear`. Required: `clear_busy` is high for exactly 256 cycles, and a subsequent read of 0xFF returns 0x00.
- Clear vs request: pulse `clear` in the same cycle as `req[1]`. Required: no `ack[1]` during clear, then `ack[1]` in the first ARB cycle.
- Re-clear: pulse `clear` again at fill cycle 100. Required: `clear_busy` stays high for 256 more cycles, with a continuous high pulse.
- Reset mid-clear: assert `reset` at fill cycle 50. Required: the next cycle has `clear_busy` = 0 and the state is ARB; `req0` is then acked immediately.
